cr_tx_fid_queue: RTL and testbench
==================================

Name: cr_tx_fid_queue

Overview:
- Ready-flow queue between the credit core's output and its transmit input.
- Accepts up to two newly-ready flow IDs per cycle, from the enqueue-path and transmit-path "became ready" outputs.
- Holds them FIFO, deduplicated per flow, and issues one flow ID per cycle back to the core's transmit-side context read.
- Pop is gated by a transmit enable from the downstream data path.

Parameters:
- DEPTH, `MAX_FLOW_CNT: queue entries; power of two; dedup guarantees no overflow at this size.
- ADDR_W, `MAX_FLOW_CNT_WIDTH: pointer width, log2(DEPTH).
- FID_W, `FLOW_ID_W: flow ID width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- enq_fid1_in  in  FID_W  newly-ready flow, port 1; `FLOW_ID_NONE = no push
- enq_fid2_in  in  FID_W  newly-ready flow, port 2; `FLOW_ID_NONE = no push
- tx_en  in  1  downstream may accept a flow this cycle
- tx_fid_out  out  FID_W  flow to transmit; `FLOW_ID_NONE = idle
- occupancy  out  ADDR_W+1  entries currently held
- overflow_err  out  1  sticky; a push was dropped

Behaviour:
- Interface:
  - One clock (clk).
  - Reset rst is synchronous and active-high.
  - All state is updated only on the rising edge of clk.
- Reset:
  - tx_fid_out = `FLOW_ID_NONE.
  - occupancy = 0.
  - overflow_err = 0.
  - Head and tail pointers = 0.
  - Queued bitmap all 0.
  - Reset mid-operation discards all entries; nothing is issued in the cycle after reset deasserts.
- State:
  - Circular buffer, DEPTH x FID_W.
  - head, tail: ADDR_W bits each; wrap naturally modulo DEPTH.
  - count: ADDR_W+1 bits.
  - queued[`MAX_FLOW_CNT-1:0]: bit set while that fid is in the buffer.
- Push qualification, per port:
  - fid != `FLOW_ID_NONE, AND
  - queued[fid] == 0 after this cycle's pop is accounted for.
  - If enq_fid1_in == enq_fid2_in, only port 1 pushes.
- Push order: port 1 is written at tail, then port 2 at tail+1 (or at tail if port 1 did not push). Tail advances by 0, 1 or 2.
- Pop:
  - Occurs when tx_en == 1 and count != 0 at the start of the cycle.
  - At the edge, tx_fid_out <= buffer[head], head advances, queued[that fid] is cleared.
  - If tx_en == 0 or count == 0: tx_fid_out <= `FLOW_ID_NONE.
  - tx_fid_out is registered and is valid for exactly one cycle per pop.
- Latency:
  - A fid pushed at edge E is poppable at edge E+1 at the earliest, if the queue was empty and tx_en == 1.
  - Input in cycle 0 gives output in cycle 2. There is no same-cycle bypass.
- Simultaneous pop and push of the same fid:
  - The pop clears the bit and the push sets it.
  - Net effect: the fid is issued now and re-queued at the tail. This is required for work-conserving round-robin.
- count update: count + pushes − pop. occupancy = count.
- Full handling:
  - Only possible if DEPTH < `MAX_FLOW_CNT.
  - Pushes beyond free space (count − pop) are dropped; port 2 is dropped first.
  - A drop sets overflow_err; it clears only on rst.
  - Bitmap bits for dropped fids are not set.
- Empty handling: no pop occurs, head is unchanged, and tx_fid_out = `FLOW_ID_NONE regardless of tx_en.
- Invariant (verification assertion): popcount(queued) == count.

Decomposition:
- Shared package/header:
  - `FLOW_ID_W, `FLOW_ID_NONE, `MAX_FLOW_CNT, `MAX_FLOW_CNT_WIDTH (existing macros).
  - Add `TXQ_PTR_W alongside them.
- One sub-module: cr_fid_ring_2w1r.
  - Contains the circular buffer, pointers and count, with 2 write enables and 1 read enable.
  - The top level owns dedup bitmap, push qualification, overflow flag and output register.

Test Plan:
- Reset then idle, with tx_en=1 and both inputs NONE for 10 cycles -> tx_fid_out = NONE, occupancy = 0, overflow_err = 0 throughout.
- Ordering: cycle 0 push fid1=3, fid2=5; cycle 1 push fid1=7; tx_en=1 -> tx_fid_out 3, 5, 7 in cycles 2, 3, 4, then NONE.
- Dedup: push 4 in cycle 0 and again in cycle 1 with tx_en=0 -> occupancy = 1. Raise tx_en -> single 4, then NONE.
- Same-port duplicate: enq_fid1_in = enq_fid2_in = 9 in one cycle -> occupancy increments by 1 only.
- Pop/re-push race: queue holds {2}; the cycle that pops 2 also pushes 2 on port 1 -> tx_fid_out = 2, occupancy stays 1, and 2 is issued again in the next cycle.
- Backpressure and wrap: DEPTH=8; push fids 1..8 in pairs with tx_en=0 (occupancy 8). Pushing 9 -> overflow_err = 1, 9 dropped. Then tx_en=1 pops 1..8 in order, pointers wrap, and a fresh push of 10 is issued correctly.

Source files
------------

// File: rtl/cr_tx_fid_queue_pkg.sv
// Shared flow-ID and transmit-queue constants for the credit core's ready-flow path.
package cr_tx_fid_queue_pkg;
    localparam int FLOW_ID_W          = 5;
    localparam int MAX_FLOW_CNT       = 16;
    localparam int MAX_FLOW_CNT_WIDTH = 4;
    localparam logic [FLOW_ID_W-1:0] FLOW_ID_NONE = '1;
    localparam int TXQ_DEPTH          = 8;
    localparam int TXQ_PTR_W          = $clog2(TXQ_DEPTH);
endpackage

// File: rtl/cr_fid_ring_2w1r.sv
// Circular flow-ID buffer with two writes and one read per cycle; the read port shows buffer[head].
module cr_fid_ring_2w1r #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int FID_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we1,
    input  logic [FID_W-1:0]  i_wd1,
    input  logic              i_we2,
    input  logic [FID_W-1:0]  i_wd2,
    input  logic              i_re,
    output logic [FID_W-1:0]  o_rd_data,
    output logic [ADDR_W:0]   o_count
);
    logic [FID_W-1:0]  r_mem [DEPTH];
    logic [ADDR_W-1:0] r_head;
    logic [ADDR_W-1:0] r_tail;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W-1:0] w_addr2;

    // Port 2 lands right behind port 1, or at the tail when port 1 is idle.
    assign w_addr2   = i_we1 ? r_tail + ADDR_W'(1) : r_tail;
    assign o_rd_data = r_mem[r_head];
    assign o_count   = r_count;

    always_ff @(posedge clk) begin
        if (i_we1) r_mem[r_tail]  <= i_wd1;
        if (i_we2) r_mem[w_addr2] <= i_wd2;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + ADDR_W'(i_re);
            r_tail  <= r_tail + ADDR_W'(i_we1) + ADDR_W'(i_we2);
            r_count <= r_count + (ADDR_W+1)'(i_we1) + (ADDR_W+1)'(i_we2)
                       - (ADDR_W+1)'(i_re);
        end
    end
endmodule

// File: rtl/cr_tx_fid_queue.sv
// Ready-flow queue: dedups newly-ready flows per fid and issues one per cycle when tx_en allows.
module cr_tx_fid_queue
    import cr_tx_fid_queue_pkg::*;
#(
    parameter int DEPTH  = TXQ_DEPTH,
    parameter int ADDR_W = TXQ_PTR_W,
    parameter int FID_W  = FLOW_ID_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FID_W-1:0]  enq_fid1_in,
    input  logic [FID_W-1:0]  enq_fid2_in,
    input  logic              tx_en,
    output logic [FID_W-1:0]  tx_fid_out,
    output logic [ADDR_W:0]   occupancy,
    output logic              overflow_err
);
    localparam logic [FID_W-1:0] NONE = FID_W'(FLOW_ID_NONE);

    logic [FID_W-1:0]        r_tx_fid;
    logic                    r_overflow;
    logic [MAX_FLOW_CNT-1:0] r_queued;

    logic [FID_W-1:0]        w_head_fid;
    logic [ADDR_W:0]         w_count;
    logic                    w_pop;
    logic [MAX_FLOW_CNT-1:0] w_pop_mask;
    logic [MAX_FLOW_CNT-1:0] w_queued_after;
    logic [MAX_FLOW_CNT-1:0] w_set1;
    logic [MAX_FLOW_CNT-1:0] w_set2;
    logic                    w_ok1;
    logic                    w_ok2;
    logic                    w_cand1;
    logic                    w_cand2;
    logic                    w_we1;
    logic                    w_we2;
    logic                    w_drop;
    logic [ADDR_W+1:0]       w_free;

    assign w_pop = tx_en && (w_count != '0);

    assign w_ok1 = (enq_fid1_in != NONE) && (int'(enq_fid1_in) < MAX_FLOW_CNT);
    assign w_ok2 = (enq_fid2_in != NONE) && (int'(enq_fid2_in) < MAX_FLOW_CNT);

    assign w_pop_mask = w_pop ? (MAX_FLOW_CNT'(1) << w_head_fid[MAX_FLOW_CNT_WIDTH-1:0]) : '0;
    // The popped fid is already out of the bitmap here, so a same-cycle re-push requeues it.
    assign w_queued_after = r_queued & ~w_pop_mask;

    assign w_cand1 = w_ok1 && !w_queued_after[enq_fid1_in[MAX_FLOW_CNT_WIDTH-1:0]];
    assign w_cand2 = w_ok2 && (enq_fid2_in != enq_fid1_in)
                     && !w_queued_after[enq_fid2_in[MAX_FLOW_CNT_WIDTH-1:0]];

    assign w_free = (ADDR_W+2)'(DEPTH) - {1'b0, w_count} + (ADDR_W+2)'(w_pop);
    assign w_we1  = w_cand1 && (w_free >= (ADDR_W+2)'(1));
    assign w_we2  = w_cand2 && (w_free >= (w_we1 ? (ADDR_W+2)'(2) : (ADDR_W+2)'(1)));
    assign w_drop = (w_cand1 && !w_we1) || (w_cand2 && !w_we2);

    assign w_set1 = w_we1 ? (MAX_FLOW_CNT'(1) << enq_fid1_in[MAX_FLOW_CNT_WIDTH-1:0]) : '0;
    assign w_set2 = w_we2 ? (MAX_FLOW_CNT'(1) << enq_fid2_in[MAX_FLOW_CNT_WIDTH-1:0]) : '0;

    cr_fid_ring_2w1r #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .FID_W  (FID_W)
    ) u_ring (
        .clk       (clk),
        .rst       (rst),
        .i_we1     (w_we1),
        .i_wd1     (enq_fid1_in),
        .i_we2     (w_we2),
        .i_wd2     (enq_fid2_in),
        .i_re      (w_pop),
        .o_rd_data (w_head_fid),
        .o_count   (w_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_fid   <= NONE;
            r_overflow <= 1'b0;
            r_queued   <= '0;
        end else begin
            r_tx_fid   <= w_pop ? w_head_fid : NONE;
            r_overflow <= r_overflow | w_drop;
            r_queued   <= w_queued_after | w_set1 | w_set2;
        end
    end

    assign tx_fid_out   = r_tx_fid;
    assign occupancy    = w_count;
    assign overflow_err = r_overflow;
endmodule

// File: tb/tb_cr_tx_fid_queue.sv
// Directed bench for cr_tx_fid_queue: ordering, dedup, pop/re-push race, overflow and wrap.
module tb_cr_tx_fid_queue;
    localparam int FW = 5;
    localparam int AW = 3;
    localparam logic [FW-1:0] NONE = '1;

    logic          clk = 1'b0;
    logic          rst;
    logic [FW-1:0] enq_fid1_in;
    logic [FW-1:0] enq_fid2_in;
    logic          tx_en;
    logic [FW-1:0] tx_fid_out;
    logic [AW:0]   occupancy;
    logic          overflow_err;

    int n_checks = 0;
    int n_errors = 0;
    logic [FW-1:0] exp_q[$];

    cr_tx_fid_queue dut (
        .clk          (clk),
        .rst          (rst),
        .enq_fid1_in  (enq_fid1_in),
        .enq_fid2_in  (enq_fid2_in),
        .tx_en        (tx_en),
        .tx_fid_out   (tx_fid_out),
        .occupancy    (occupancy),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [FW-1:0] f1, input logic [FW-1:0] f2, input logic en);
        enq_fid1_in = f1;
        enq_fid2_in = f2;
        tx_en       = en;
    endtask

    // One rising edge, then sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [FW-1:0] fid, input int occ);
        check({tag, "_fid"}, 32'(tx_fid_out), 32'(fid));
        check({tag, "_occ"}, 32'(occupancy), 32'(occ));
    endtask

    initial begin
        rst = 1'b1;
        drive(NONE, NONE, 1'b1);
        tick();
        tick();
        rst = 1'b0;
        expect_out("reset", NONE, 0);
        check("reset_ovf", 32'(overflow_err), 0);

        // Idle with tx_en high
        for (int i = 0; i < 10; i++) begin
            tick();
            expect_out("idle", NONE, 0);
            check("idle_ovf", 32'(overflow_err), 0);
        end

        // Ordering: 3,5 then 7
        drive(5'd3, 5'd5, 1'b1);
        tick();
        expect_out("ord0", NONE, 2);
        drive(5'd7, NONE, 1'b1);
        tick();
        expect_out("ord1", 5'd3, 2);
        drive(NONE, NONE, 1'b1);
        tick();
        expect_out("ord2", 5'd5, 1);
        tick();
        expect_out("ord3", 5'd7, 0);
        tick();
        expect_out("ord4", NONE, 0);

        // Dedup across cycles
        drive(5'd4, NONE, 1'b0);
        tick();
        expect_out("dup0", NONE, 1);
        tick();
        expect_out("dup1", NONE, 1);
        drive(NONE, NONE, 1'b1);
        tick();
        expect_out("dup2", 5'd4, 0);
        tick();
        expect_out("dup3", NONE, 0);

        // Same fid on both ports in one cycle
        drive(5'd9, 5'd9, 1'b0);
        tick();
        expect_out("same0", NONE, 1);
        drive(NONE, NONE, 1'b1);
        tick();
        expect_out("same1", 5'd9, 0);
        tick();
        expect_out("same2", NONE, 0);

        // Pop/re-push race on fid 2
        drive(5'd2, NONE, 1'b0);
        tick();
        expect_out("race0", NONE, 1);
        drive(5'd2, NONE, 1'b1);
        tick();
        expect_out("race1", 5'd2, 1);
        drive(NONE, NONE, 1'b1);
        tick();
        expect_out("race2", 5'd2, 0);
        tick();
        expect_out("race3", NONE, 0);

        // Fill to 8 with pairs, then overflow with 9
        for (int i = 0; i < 4; i++) begin
            drive(FW'(2*i+1), FW'(2*i+2), 1'b0);
            exp_q.push_back(FW'(2*i+1));
            exp_q.push_back(FW'(2*i+2));
            tick();
            expect_out("fill", NONE, 2*i+2);
        end
        check("fill_ovf", 32'(overflow_err), 0);
        drive(5'd9, NONE, 1'b0);
        tick();
        expect_out("full", NONE, 8);
        check("full_ovf", 32'(overflow_err), 1);

        // Drain in order; pointers wrap
        drive(NONE, NONE, 1'b1);
        for (int i = 0; i < 8; i++) begin
            tick();
            expect_out("drain", exp_q.pop_front(), 7 - i);
        end
        check("drain_ovf_sticky", 32'(overflow_err), 1);
        drive(5'd10, NONE, 1'b1);
        tick();
        expect_out("fresh0", NONE, 1);
        drive(NONE, NONE, 1'b1);
        tick();
        expect_out("fresh1", 5'd10, 0);
        tick();
        expect_out("fresh2", NONE, 0);

        // Reset mid-operation discards entries and clears the sticky flag
        drive(5'd6, 5'd11, 1'b0);
        tick();
        expect_out("mid0", NONE, 2);
        rst = 1'b1;
        drive(NONE, NONE, 1'b1);
        tick();
        rst = 1'b0;
        expect_out("mid_rst", NONE, 0);
        check("mid_rst_ovf", 32'(overflow_err), 0);
        tick();
        expect_out("mid_after", NONE, 0);

        // Fid 6 no longer marked queued after reset
        drive(5'd6, NONE, 1'b1);
        tick();
        expect_out("req0", NONE, 1);
        drive(NONE, NONE, 1'b1);
        tick();
        expect_out("req1", 5'd6, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
